// File: rtl/gen_mux_sel_ctrl_if.sv
// Handshake bundle between the bank write/read-address side and the bit-select controller.
interface gen_mux_sel_ctrl_if #(
  parameter int SEL_W  = 3,
  parameter int BANK_W = 1
);
  logic              BANK_WR_DONE;
  logic              RD_EN;
  logic              MODE_REV;
  logic              SOFT_CLR;
  logic [SEL_W-1:0]  CTRL_BIT_SEL;
  logic [BANK_W-1:0] RD_BANK_SEL;
  logic              RD_VALID;
  logic              READ_ONE_MATRIX;
  logic              READ_ONE_BANK;
  logic [BANK_W:0]   FULL_CNT;
  logic              OVERFLOW;

  modport master (
    output BANK_WR_DONE, RD_EN, MODE_REV, SOFT_CLR,
    input  CTRL_BIT_SEL, RD_BANK_SEL, RD_VALID, READ_ONE_MATRIX,
           READ_ONE_BANK, FULL_CNT, OVERFLOW
  );

  modport slave (
    input  BANK_WR_DONE, RD_EN, MODE_REV, SOFT_CLR,
    output CTRL_BIT_SEL, RD_BANK_SEL, RD_VALID, READ_ONE_MATRIX,
           READ_ONE_BANK, FULL_CNT, OVERFLOW
  );
endinterface

// File: rtl/gen_mux_sel_ctrl.sv
// Read-side bit-select controller: steps a lane select across SEL_NUM lanes,
// counts matrices per bank, walks ping-pong banks and tracks full/unread banks.
module gen_mux_sel_ctrl #(
  parameter int SEL_NUM      = 8,
  parameter int SEL_W        = 3,
  parameter int NUM_BANK     = 2,
  parameter int BANK_W       = 1,
  parameter int MTX_PER_BANK = 4,
  parameter int MTX_W        = 2
) (
  input  logic               SYS_CLK,
  input  logic               SYS_RST,
  gen_mux_sel_ctrl_if.slave  bus
);

  localparam logic [SEL_W-1:0]  POS_LAST  = SEL_W'(SEL_NUM - 1);
  localparam logic [MTX_W-1:0]  MTX_LAST  = MTX_W'(MTX_PER_BANK - 1);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANK - 1);
  localparam logic [BANK_W:0]   FULL_MAX  = (BANK_W+1)'(NUM_BANK);

  logic [SEL_W-1:0]  pos;
  logic              mode_q;
  logic [MTX_W-1:0]  mtx;
  logic [BANK_W-1:0] bank;
  logic [BANK_W:0]   full_cnt;
  logic              overflow;

  logic rd_valid;
  logic acc;
  logic rd_mtx;
  logic rd_bank;
  logic full_hit;

  // Saturating full-bank count: simultaneous fill and release cancel out.
  function automatic logic [BANK_W:0] full_step(input logic [BANK_W:0] cnt,
                                                input logic up, input logic down);
    logic [BANK_W:0] res;
    res = cnt;
    if (up && !down && cnt != FULL_MAX) res = cnt + 1'b1;
    else if (down && !up)               res = cnt - 1'b1;
    return res;
  endfunction

  function automatic logic [SEL_W-1:0] lane_map(input logic [SEL_W-1:0] p, input logic rev);
    return rev ? (POS_LAST - p) : p;
  endfunction

  always_comb begin
    rd_valid = (full_cnt != '0);
    acc      = bus.RD_EN & rd_valid & ~bus.SOFT_CLR;
    rd_mtx   = acc & (pos == POS_LAST);
    rd_bank  = rd_mtx & (mtx == MTX_LAST);
    full_hit = bus.BANK_WR_DONE & ~rd_bank & (full_cnt == FULL_MAX);
  end

  assign bus.CTRL_BIT_SEL    = lane_map(pos, mode_q);
  assign bus.RD_BANK_SEL     = bank;
  assign bus.RD_VALID        = rd_valid;
  assign bus.READ_ONE_MATRIX = rd_mtx;
  assign bus.READ_ONE_BANK   = rd_bank;
  assign bus.FULL_CNT        = full_cnt;
  assign bus.OVERFLOW        = overflow;

  // Bit order is latched while idle at lane origin, so mid-matrix changes are ignored.
  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      pos    <= '0;
      mode_q <= 1'b0;
    end else if (bus.SOFT_CLR) begin
      pos    <= '0;
      mode_q <= 1'b0;
    end else begin
      if (pos == '0) mode_q <= bus.MODE_REV;
      if (acc)       pos    <= (pos == POS_LAST) ? '0 : pos + 1'b1;
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      mtx  <= '0;
      bank <= '0;
    end else if (bus.SOFT_CLR) begin
      mtx  <= '0;
      bank <= '0;
    end else begin
      if (rd_mtx)  mtx  <= (mtx == MTX_LAST) ? '0 : mtx + 1'b1;
      if (rd_bank) bank <= (bank == BANK_LAST) ? '0 : bank + 1'b1;
    end
  end

  // OVERFLOW survives a soft clear; only the hard reset drops it.
  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      full_cnt <= '0;
      overflow <= 1'b0;
    end else if (bus.SOFT_CLR) begin
      full_cnt <= '0;
    end else begin
      full_cnt <= full_step(full_cnt, bus.BANK_WR_DONE, rd_bank);
      if (full_hit) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gen_mux_sel_ctrl.sv
// Scoreboard bench: two controller configurations driven in lockstep and compared against a step-count model.
module tb_gen_mux_sel_ctrl;

  typedef struct packed {
    logic [2:0] sel;
    logic       bank;
    logic       valid;
    logic       rom;
    logic       rob;
    logic [1:0] full;
    logic       ovf;
  } exp_t;

  logic SYS_CLK = 1'b0;
  logic SYS_RST = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  gen_mux_sel_ctrl_if #(.SEL_W(3), .BANK_W(1)) b0 ();
  gen_mux_sel_ctrl_if #(.SEL_W(3), .BANK_W(1)) b1 ();

  gen_mux_sel_ctrl u0 (.SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .bus(b0));

  gen_mux_sel_ctrl #(
    .SEL_NUM(5), .SEL_W(3), .NUM_BANK(2), .BANK_W(1), .MTX_PER_BANK(2), .MTX_W(1)
  ) u1 (.SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .bus(b1));

  int   lanes [2] = '{8, 5};
  int   mpb   [2] = '{4, 2};
  int   nbank = 2;
  int   steps [2];
  int   fullm [2];
  bit   ovfm  [2];
  bit   modem [2];

  exp_t q0 [$];
  exp_t q1 [$];
  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;

  // Reference: everything derives from the number of accepted steps since clear.
  task automatic model(input int i, input bit rn, input bit bwd, input bit rd,
                       input bit mr, input bit sc, output exp_t e);
    int  p;
    bit  vld, acc, rom, rob;
    e = '0;
    if (!rn) begin
      steps[i] = 0; fullm[i] = 0; ovfm[i] = 0; modem[i] = 0;
    end else begin
      p   = steps[i] % lanes[i];
      vld = (fullm[i] != 0);
      acc = rd && vld && !sc;
      rom = acc && (p == lanes[i] - 1);
      rob = rom && (((steps[i] / lanes[i]) % mpb[i]) == mpb[i] - 1);
      e.sel   = 3'(modem[i] ? (lanes[i] - 1 - p) : p);
      e.bank  = 1'((steps[i] / (lanes[i] * mpb[i])) % nbank);
      e.valid = vld;
      e.rom   = rom;
      e.rob   = rob;
      e.full  = 2'(fullm[i]);
      e.ovf   = ovfm[i];
      if (sc) begin
        steps[i] = 0; fullm[i] = 0; modem[i] = 0;
      end else begin
        if (p == 0) modem[i] = mr;
        if (acc) steps[i]++;
        if (bwd && !rob) begin
          if (fullm[i] == nbank) ovfm[i] = 1;
          else fullm[i]++;
        end else if (rob && !bwd) begin
          fullm[i]--;
        end
      end
    end
  endtask

  task automatic cyc(input bit rn, input bit bwd, input bit rd, input bit mr, input bit sc);
    exp_t e;
    @(posedge SYS_CLK);
    #1;
    SYS_RST = rn;
    b0.BANK_WR_DONE = bwd; b0.RD_EN = rd; b0.MODE_REV = mr; b0.SOFT_CLR = sc;
    b1.BANK_WR_DONE = bwd; b1.RD_EN = rd; b1.MODE_REV = mr; b1.SOFT_CLR = sc;
    model(0, rn, bwd, rd, mr, sc, e);
    q0.push_back(e);
    model(1, rn, bwd, rd, mr, sc, e);
    q1.push_back(e);
  endtask

  exp_t want0, want1, got0, got1;

  always @(negedge SYS_CLK) begin
    cycle++;
    if (q0.size() > 0) begin
      want0 = q0.pop_front();
      got0  = {b0.CTRL_BIT_SEL, b0.RD_BANK_SEL, b0.RD_VALID, b0.READ_ONE_MATRIX,
               b0.READ_ONE_BANK, b0.FULL_CNT, b0.OVERFLOW};
      total++;
      if (got0 !== want0) begin
        bad++;
        $display("FAIL sel8_outputs cycle=%0d got sel=%0d bank=%0d vld=%b rom=%b rob=%b full=%0d ovf=%b want sel=%0d bank=%0d vld=%b rom=%b rob=%b full=%0d ovf=%b",
                 cycle, got0.sel, got0.bank, got0.valid, got0.rom, got0.rob, got0.full, got0.ovf,
                 want0.sel, want0.bank, want0.valid, want0.rom, want0.rob, want0.full, want0.ovf);
      end
    end
    if (q1.size() > 0) begin
      want1 = q1.pop_front();
      got1  = {b1.CTRL_BIT_SEL, b1.RD_BANK_SEL, b1.RD_VALID, b1.READ_ONE_MATRIX,
               b1.READ_ONE_BANK, b1.FULL_CNT, b1.OVERFLOW};
      total++;
      if (got1 !== want1) begin
        bad++;
        $display("FAIL sel5_outputs cycle=%0d got sel=%0d bank=%0d vld=%b rom=%b rob=%b full=%0d ovf=%b want sel=%0d bank=%0d vld=%b rom=%b rob=%b full=%0d ovf=%b",
                 cycle, got1.sel, got1.bank, got1.valid, got1.rom, got1.rob, got1.full, got1.ovf,
                 want1.sel, want1.bank, want1.valid, want1.rom, want1.rob, want1.full, want1.ovf);
      end
    end
  end

  initial begin
    b0.BANK_WR_DONE = 0; b0.RD_EN = 0; b0.MODE_REV = 0; b0.SOFT_CLR = 0;
    b1.BANK_WR_DONE = 0; b1.RD_EN = 0; b1.MODE_REV = 0; b1.SOFT_CLR = 0;

    // reset state, then idle
    repeat (3) cyc(0, 0, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0);

    // one bank, forward order, 32 steps
    cyc(1, 1, 0, 0, 0);
    repeat (32) cyc(1, 0, 1, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0);

    // reverse order latched at matrix start, MODE_REV dropped at step 3
    cyc(1, 1, 0, 1, 0);
    repeat (3) cyc(1, 0, 1, 1, 0);
    repeat (5) cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (8) cyc(1, 0, 1, 0, 0);

    // stall while empty, then resume from lane origin
    cyc(1, 0, 0, 0, 1);
    repeat (10) cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    repeat (6) cyc(1, 0, 1, 0, 0);

    // overflow, sticky through soft clear
    cyc(1, 0, 0, 0, 1);
    repeat (3) cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);

    // bank fill coincident with final step of a bank
    cyc(1, 1, 0, 0, 0);
    repeat (31) cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0);

    // async reset mid-matrix, restart at bank 0 lane 0
    cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0);
    repeat (3) cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    repeat (12) cyc(1, 0, 1, 0, 0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit rn, bwd, rd, mr, sc;
      rn  = ($urandom_range(0, 149) != 0);
      bwd = ($urandom_range(0, 5) == 0);
      rd  = ($urandom_range(0, 3) != 0);
      mr  = 1'($urandom_range(0, 1));
      sc  = ($urandom_range(0, 59) == 0);
      cyc(rn, bwd, rd, mr, sc);
    end

    repeat (2) cyc(1, 0, 0, 0, 0);
    @(negedge SYS_CLK);
    #1;
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got q0=%0d q1=%0d want 0 0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gen_mux_sel_ctrl.md
Name: gen_mux_sel_ctrl

Overview:
Parametrised read-side bit-select controller for the matrix bit-serial mux path. It generalises the fixed 1-of-8 select counter to SEL_NUM lanes and adds multi-bank ping-pong tracking, stall-on-empty handshaking and a selectable forward/reverse bit order. It sits between the bank write logic (bank-full events) and the read-address generator, and drives the bit-mux select and the per-matrix and per-bank completion strobes.

Parameters:
SEL_NUM, 8, number of mux lanes (bits per matrix word), 2..256
SEL_W, 3, select width, must satisfy 2**SEL_W >= SEL_NUM
NUM_BANK, 2, number of ping-pong buffer banks, 2..8
BANK_W, 1, bank index width, must satisfy 2**BANK_W >= NUM_BANK
MTX_PER_BANK, 4, matrices held per bank, >= 1
MTX_W, 2, matrix counter width, must satisfy 2**MTX_W >= MTX_PER_BANK

Ports:
SYS_CLK  in  1  clock, rising edge
SYS_RST  in  1  asynchronous reset, active-low
BANK_WR_DONE  in  1  one-cycle pulse: write side has completely filled one bank
RD_EN  in  1  read-address generator requests one select step
MODE_REV  in  1  bit order: 0 = lane 0 first, 1 = lane SEL_NUM-1 first
SOFT_CLR  in  1  synchronous clear of all state except OVERFLOW
CTRL_BIT_SEL  out  SEL_W  current mux lane select
RD_BANK_SEL  out  BANK_W  bank currently being read
RD_VALID  out  1  at least one full bank is available (FULL_CNT != 0)
READ_ONE_MATRIX  out  1  pulse: accepted step that completes a matrix
READ_ONE_BANK  out  1  pulse: accepted step that completes a bank; also the bank release
FULL_CNT  out  BANK_W+1  number of full, unread banks
OVERFLOW  out  1  sticky: bank-full event received while all banks were full

Behaviour:
- Reset (SYS_RST low, asynchronous) clears everything. pos=0, mode_q=0, mtx=0, RD_BANK_SEL=0 and FULL_CNT=0. All outputs read 0, including CTRL_BIT_SEL=0, RD_VALID=0 and OVERFLOW=0.
- Accepted step: acc = RD_EN & RD_VALID.
- RD_EN while RD_VALID=0 is a stall: it is ignored and no counter moves.
- RD_VALID is combinational from FULL_CNT.
- Internal position counter pos ranges 0..SEL_NUM-1.
  - On acc: pos <= (pos==SEL_NUM-1) ? 0 : pos+1.
  - pos wraps at SEL_NUM, not at 2**SEL_W.
- mode_q is loaded from MODE_REV on every clock where pos==0. It holds constant for the rest of the matrix, so MODE_REV changes mid-matrix have no effect.
- CTRL_BIT_SEL is combinational from registers:
  - mode_q=0: CTRL_BIT_SEL = pos
  - mode_q=1: CTRL_BIT_SEL = SEL_NUM-1-pos
- READ_ONE_MATRIX = acc & (pos==SEL_NUM-1). It is combinational, in the same cycle as the last lane's step.
- Matrix counter mtx: on READ_ONE_MATRIX, mtx <= (mtx==MTX_PER_BANK-1) ? 0 : mtx+1.
- READ_ONE_BANK = READ_ONE_MATRIX & (mtx==MTX_PER_BANK-1). On it, RD_BANK_SEL advances modulo NUM_BANK (wraps NUM_BANK-1 -> 0).
- FULL_CNT update at each edge:
  - +1 on BANK_WR_DONE alone
  - -1 on READ_ONE_BANK alone
  - unchanged when both occur in the same cycle
- Overflow: BANK_WR_DONE with FULL_CNT==NUM_BANK and no simultaneous READ_ONE_BANK sets OVERFLOW=1. FULL_CNT saturates at NUM_BANK.
- OVERFLOW clears only on SYS_RST; SOFT_CLR does not clear it.
- Underflow cannot occur, because READ_ONE_BANK requires RD_VALID.
- SOFT_CLR has priority over every other event in its cycle. It returns pos, mode_q, mtx, RD_BANK_SEL and FULL_CNT to their reset values. Strobes are forced to 0 in the SOFT_CLR cycle.
- Reset asserted mid-matrix abandons the partial matrix. After release, reading restarts at bank 0, lane origin.
- Latency: a bank-full pulse at edge N gives RD_VALID=1 after edge N, so the first step can be accepted in cycle N+1.

Test Plan:
- Defaults, MODE_REV=0, one BANK_WR_DONE pulse, RD_EN held high for 32 cycles -> CTRL_BIT_SEL sequence 0..7 repeated 4 times. READ_ONE_MATRIX on each sel=7 step. READ_ONE_BANK on step 32, then RD_VALID=0, FULL_CNT=0, RD_BANK_SEL=1.
- MODE_REV=1 at matrix start, toggled to 0 at step 3 -> sel 7,6,5,...,0 for that matrix. The next matrix uses the new MODE_REV=0 order 0..7.
- RD_EN=1 with FULL_CNT=0 for 10 cycles -> CTRL_BIT_SEL stays 0 and no strobes. After one BANK_WR_DONE, stepping resumes from sel 0.
- Three BANK_WR_DONE pulses with NUM_BANK=2 and no reads -> FULL_CNT=2, OVERFLOW=1 after the third. OVERFLOW stays 1 after SOFT_CLR.
- FULL_CNT=1, BANK_WR_DONE in the same cycle as the final step of a bank -> FULL_CNT stays 1 and RD_BANK_SEL advances 0->1.
- SEL_NUM=5, SEL_W=3: 10 accepted steps -> sel 0,1,2,3,4,0,1,2,3,4 with READ_ONE_MATRIX at steps 5 and 10. Async reset at step 3 of a third run -> all outputs 0 immediately.
